// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked
// bits and ACK, driving the open-drain lines through pull-low enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [7:0] TX_Data,
    input  logic       TX_Start,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    output logic       SCL_OE,
    output logic       SDA_OE,
    output logic       Busy,
    output logic       Done,
    output logic       Ack_Error,
    output logic       Timeout_Error
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
    localparam logic [19:0]   TMO      = 20'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] inh_q, inh_d;
    logic [19:0]   tmr_q, tmr_d;
    logic [3:0]    bit_q, bit_d;
    logic [8:0]    shift_q, shift_d;
    logic          scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic          ack_q, ack_d, to_q, to_d;
    logic          scl_s1_q, scl_s2_q, scl_prev_q, sda_s1_q, sda_s2_q;
    logic          fall, timed;

    // Synchronisers idle high so reset does not fake a falling edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
        end else begin
            scl_s1_q   <= SCL_IN;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= SDA_IN;
            sda_s2_q   <= sda_s1_q;
        end
    end

    assign fall  = scl_prev_q & ~scl_s2_q;
    assign timed = (state_q == S_RTS) || (state_q == S_DATA) ||
                   (state_q == S_ACK) || (state_q == S_WAIT_IDLE);

    always_comb begin
        state_d  = state_q;
        inh_d    = inh_q;
        tmr_d    = tmr_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        scl_oe_d = scl_oe_q;
        sda_oe_d = sda_oe_q;
        ack_d    = ack_q;
        to_d     = to_q;
        if (timed) tmr_d = fall ? 20'd0 : tmr_q + 20'd1;
        case (state_q)
            S_IDLE: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
                if (TX_Start) begin
                    shift_d  = {~^TX_Data, TX_Data};
                    inh_d    = '0;
                    bit_d    = 4'd0;
                    ack_d    = 1'b0;
                    to_d     = 1'b0;
                    scl_oe_d = 1'b1;
                    state_d  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                inh_d = inh_q + 1'b1;
                if (inh_q == INH_PRE) sda_oe_d = 1'b1;
                if (inh_q == INH_LAST) begin
                    scl_oe_d = 1'b0;
                    sda_oe_d = 1'b1;
                    tmr_d    = 20'd0;
                    state_d  = S_RTS;
                end
            end
            S_RTS: begin
                if (fall) begin
                    sda_oe_d = ~shift_q[0];
                    shift_d  = {1'b0, shift_q[8:1]};
                    bit_d    = 4'd1;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                // bit_q counts edges already seen; the 10th edge is the stop bit.
                if (fall) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_ACK;
                    end else begin
                        sda_oe_d = ~shift_q[0];
                        shift_d  = {1'b0, shift_q[8:1]};
                    end
                end
            end
            S_ACK: begin
                if (fall) begin
                    ack_d   = sda_s2_q;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (scl_s2_q && sda_s2_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timed && tmr_q == TMO) begin
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            to_d     = 1'b1;
            state_d  = S_DONE;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            inh_q    <= '0;
            tmr_q    <= 20'd0;
            bit_q    <= 4'd0;
            shift_q  <= 9'd0;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            ack_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            inh_q    <= inh_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            ack_q    <= ack_d;
            to_q     <= to_d;
        end
    end

    assign SCL_OE        = scl_oe_q;
    assign SDA_OE        = sda_oe_q;
    assign Busy          = (state_q != S_IDLE);
    assign Done          = (state_q == S_DONE);
    assign Ack_Error     = ack_q;
    assign Timeout_Error = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a device model clocks frames out of the host while a
// scoreboard monitor checks every Done pulse against queued expectations.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_scl = 1'b1, dev_sda = 1'b1;
    logic       scl_oe, sda_oe, busy, done, ack_err, to_err;
    logic       scl_line, sda_line;

    assign scl_line = dev_scl & ~scl_oe;
    assign sda_line = dev_sda & ~sda_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200)) dut (
        .CLOCK(clk), .RESET(rst), .TX_Data(tx_data), .TX_Start(tx_start),
        .SCL_IN(scl_line), .SDA_IN(sda_line), .SCL_OE(scl_oe), .SDA_OE(sda_oe),
        .Busy(busy), .Done(done), .Ack_Error(ack_err), .Timeout_Error(to_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0] bits;
        logic        chk_bits;
        logic        ack;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    logic [10:0] rec;
    int          checks = 0, errors = 0;
    int          run = 0, inh_len = 0, sda_at = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Inhibit tracker and scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (scl_oe) begin
            if (run == 0) sda_at = 0;
            run++;
            if (sda_oe && sda_at == 0) sda_at = run;
        end else if (run != 0) begin
            inh_len = run;
            run = 0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                if (e.chk_bits) chk("frame_bits", int'(rec), int'(e.bits));
                chk("ack_error", int'(ack_err), int'(e.ack));
                chk("timeout_error", int'(to_err), int'(e.to));
                chk("oe_released_at_done", int'({scl_oe, sda_oe}), 0);
                chk("inhibit_len", inh_len, 20);
                chk("start_bit_cycle", sda_at, 20);
            end
        end
    end

    // mode: 0 = device ACKs, 1 = no ACK, 2 = device never clocks, 3 = reset after edge 5
    task automatic xfer(input logic [7:0] d, input logic par, input int mode);
        exp_t e;
        int   n;
        bit   seen;
        e.bits     = {1'b1, par, d, 1'b0};
        e.chk_bits = (mode < 2);
        e.ack      = (mode == 1);
        e.to       = (mode == 2);
        if (mode != 3) sb.push_back(e);
        @(posedge clk); #1;
        tx_data = d; tx_start = 1'b1;
        cyc(1);
        tx_start = 1'b0; tx_data = 8'h00;
        @(negedge clk);
        chk("accept_busy", int'(busy), 1);
        chk("accept_scl_oe", int'(scl_oe), 1);
        chk("accept_flags_clear", int'({ack_err, to_err}), 0);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (sda_oe && !scl_oe) seen = 1;
        end
        if (!seen) begin
            chk("rts_reached", 0, 1);
            return;
        end
        if (mode == 2) begin
            n = 0;
            while (!done && n < 1000) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", n, 201);
        end else begin
            rec = '1;
            cyc(10);
            rec[0] = sda_line;
            for (int k = 1; k <= 11; k++) begin
                if (k == 11 && mode == 0) begin
                    dev_sda = 1'b0;
                    cyc(5);
                end
                dev_scl = 1'b0;
                if (k == 4) begin
                    cyc(10);
                    tx_data = 8'hAA; tx_start = 1'b1;
                    cyc(1);
                    tx_start = 1'b0; tx_data = 8'h00;
                    cyc(9);
                end else if (k == 5 && mode == 3) begin
                    cyc(10);
                    rst = 1'b1;
                    cyc(1);
                    chk("reset_oe", int'({scl_oe, sda_oe}), 0);
                    chk("reset_busy", int'(busy), 0);
                    chk("reset_no_done", int'(done), 0);
                    rst = 1'b0;
                    dev_scl = 1'b1; dev_sda = 1'b1;
                    cyc(40);
                    chk("reset_idle", int'({busy, scl_oe, sda_oe}), 0);
                    return;
                end else begin
                    cyc(20);
                end
                dev_scl = 1'b1;
                if (k <= 10) rec[k] = sda_line;
                if (k == 1 || k == 6) chk("busy_mid_frame", int'(busy), 1);
                cyc(20);
                if (k == 11) dev_sda = 1'b1;
            end
        end
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("busy_falls", 1, 0);
        cyc(5);
    endtask

    initial begin
        cyc(3);
        @(negedge clk);
        chk("reset_state", int'({scl_oe, sda_oe, busy, done, ack_err, to_err}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(5);
        xfer(8'hED, 1'b1, 0);
        xfer(8'h07, 1'b0, 0);
        xfer(8'h00, 1'b1, 0);
        xfer(8'hED, 1'b1, 1);
        xfer(8'hED, 1'b1, 2);
        chk("timeout_flag_holds", int'(to_err), 1);
        xfer(8'h07, 1'b0, 0);
        xfer(8'h5A, 1'b1, 3);
        xfer(8'hF4, 1'b0, 0);
        cyc(20);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
